// File: rtl/cdbus_host.sv
// cdbus_host: CSR bus master for a single cdbus controller.
//
// The block polls the controller's interrupt flag register. It streams
// received frame bytes out on the rx_* interface and writes outbound frame
// bytes taken from the tx_* interface into the controller's TX buffer.
// Byte index 2 of every frame carries the payload length, so the last byte
// of a frame sits at index len+2.
//
// Ports:
//   clk, reset_n        clock (rising edge), synchronous active-low reset
//   irq                 controller interrupt line; used only as a wake-up hint
//   csr_address         CSR address (registered)
//   csr_read            one-cycle read strobe; csr_readdata is valid one cycle later
//   csr_readdata        CSR read data
//   csr_write           one-cycle write strobe
//   csr_writedata       CSR write data (registered)
//   tx_data/valid/last  outbound frame byte stream; tx_ready accepts a byte
//   rx_data/valid/last  inbound frame byte stream; rx_ready consumes a byte
//   tx_err              one-cycle pulse when the outbound frame length is wrong
//   busy                high whenever the controller FSM is not idle
module cdbus_host #(
    parameter logic [4:0] ADDR_INT_FLAG = 5'h10,
    parameter logic [4:0] ADDR_RX_DATA  = 5'h14,
    parameter logic [4:0] ADDR_TX_DATA  = 5'h15,
    parameter logic [4:0] ADDR_RX_CTRL  = 5'h16,
    parameter logic [4:0] ADDR_TX_CTRL  = 5'h17
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       irq,
    output logic [4:0] csr_address,
    output logic       csr_read,
    input  logic [7:0] csr_readdata,
    output logic       csr_write,
    output logic [7:0] csr_writedata,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_last,
    input  logic       rx_ready,
    output logic       tx_err,
    output logic       busy
);

    typedef enum logic [3:0] {
        IDLE, POLL, POLL_WAIT, RX_RD, RX_WAIT, RX_OUT, RX_CLR,
        TX_LOAD, TX_START, TX_WAIT, TX_ABORT
    } state_t;

    // What TX_LOAD does once the data write of the byte just accepted is out.
    typedef enum logic [1:0] {
        AFTER_NEXT, AFTER_START, AFTER_ABORT, AFTER_DRAIN
    } tx_after_t;

    state_t    state, state_d;
    tx_after_t tx_after, tx_after_d;
    logic      armed;
    logic [7:0] poll_cnt, poll_cnt_d;
    logic [8:0] idx, idx_d;
    logic [7:0] len, len_d;

    logic       csr_read_d, csr_write_d, tx_ready_d, rx_valid_d, rx_last_d, tx_err_d;
    logic [4:0] csr_address_d;
    logic [7:0] csr_writedata_d, rx_data_d;
    logic       tx_final;

    // True when byte index i is the last byte of the frame. At index 2 the
    // length is the byte currently on the bus, not yet the stored value.
    function automatic logic is_final(input logic [8:0] i, input logic [7:0] cur,
                                      input logic [7:0] saved);
        logic [7:0] l;
        l = (i == 9'd2) ? cur : saved;
        return i == ({1'b0, l} + 9'd2);
    endfunction

    assign tx_final = is_final(idx, tx_data, len);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            tx_after      <= AFTER_NEXT;
            armed         <= 1'b0;
            poll_cnt      <= 8'd0;
            idx           <= 9'd0;
            len           <= 8'd0;
            csr_read      <= 1'b0;
            csr_write     <= 1'b0;
            csr_address   <= 5'd0;
            csr_writedata <= 8'd0;
            tx_ready      <= 1'b0;
            rx_data       <= 8'd0;
            rx_valid      <= 1'b0;
            rx_last       <= 1'b0;
            tx_err        <= 1'b0;
            busy          <= 1'b0;
        end else begin
            state         <= state_d;
            tx_after      <= tx_after_d;
            armed         <= 1'b1;
            poll_cnt      <= poll_cnt_d;
            idx           <= idx_d;
            len           <= len_d;
            csr_read      <= csr_read_d;
            csr_write     <= csr_write_d;
            csr_address   <= csr_address_d;
            csr_writedata <= csr_writedata_d;
            tx_ready      <= tx_ready_d;
            rx_data       <= rx_data_d;
            rx_valid      <= rx_valid_d;
            rx_last       <= rx_last_d;
            tx_err        <= tx_err_d;
            busy          <= (state_d != IDLE);
        end
    end

    // Next-state logic also produces the next value of every registered
    // output, so strobes appear in the cycle the FSM sits in the issuing state.
    always_comb begin
        state_d         = state;
        tx_after_d      = tx_after;
        poll_cnt_d      = poll_cnt;
        idx_d           = idx;
        len_d           = len;
        csr_read_d      = 1'b0;
        csr_write_d     = 1'b0;
        csr_address_d   = csr_address;
        csr_writedata_d = csr_writedata;
        tx_ready_d      = 1'b0;
        rx_data_d       = rx_data;
        rx_valid_d      = rx_valid;
        rx_last_d       = rx_last;
        tx_err_d        = 1'b0;

        case (state)
            IDLE: begin
                poll_cnt_d = poll_cnt + 8'd1;
                // armed holds off any CSR access in the first cycle after reset.
                if (armed && (irq || tx_valid || poll_cnt == 8'hFF)) begin
                    state_d       = POLL;
                    csr_read_d    = 1'b1;
                    csr_address_d = ADDR_INT_FLAG;
                end
            end
            POLL: state_d = POLL_WAIT;
            POLL_WAIT: begin
                idx_d = 9'd0;
                if (csr_readdata[1]) begin
                    state_d       = RX_RD;
                    csr_read_d    = 1'b1;
                    csr_address_d = ADDR_RX_DATA;
                end else if (csr_readdata[5] && tx_valid) begin
                    state_d    = TX_LOAD;
                    tx_ready_d = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RX_RD: state_d = RX_WAIT;
            RX_WAIT: begin
                rx_data_d  = csr_readdata;
                rx_valid_d = 1'b1;
                rx_last_d  = is_final(idx, csr_readdata, len);
                if (idx == 9'd2) len_d = csr_readdata;
                state_d = RX_OUT;
            end
            RX_OUT: begin
                if (rx_ready) begin
                    rx_valid_d = 1'b0;
                    rx_last_d  = 1'b0;
                    idx_d      = idx + 9'd1;
                    if (rx_last) begin
                        state_d         = RX_CLR;
                        csr_write_d     = 1'b1;
                        csr_address_d   = ADDR_RX_CTRL;
                        csr_writedata_d = 8'h02;
                    end else begin
                        state_d       = RX_RD;
                        csr_read_d    = 1'b1;
                        csr_address_d = ADDR_RX_DATA;
                    end
                end
            end
            RX_CLR: state_d = IDLE;
            TX_LOAD: begin
                if (tx_ready) begin
                    // Accept phase: a byte taken now is written next cycle.
                    if (tx_valid) begin
                        csr_write_d     = 1'b1;
                        csr_address_d   = ADDR_TX_DATA;
                        csr_writedata_d = tx_data;
                        idx_d           = idx + 9'd1;
                        if (idx == 9'd2) len_d = tx_data;
                        if (tx_last) tx_after_d = tx_final ? AFTER_START : AFTER_ABORT;
                        else         tx_after_d = tx_final ? AFTER_DRAIN : AFTER_NEXT;
                    end else begin
                        tx_ready_d = 1'b1;
                    end
                end else begin
                    // Write phase: the data write is on the bus this cycle.
                    case (tx_after)
                        AFTER_START: begin
                            state_d         = TX_START;
                            csr_write_d     = 1'b1;
                            csr_address_d   = ADDR_TX_CTRL;
                            csr_writedata_d = 8'h02;
                        end
                        AFTER_ABORT: begin
                            state_d         = TX_ABORT;
                            csr_write_d     = 1'b1;
                            csr_address_d   = ADDR_TX_CTRL;
                            csr_writedata_d = 8'h04;
                            tx_err_d        = 1'b1;
                        end
                        AFTER_DRAIN: begin
                            state_d    = TX_ABORT;
                            tx_ready_d = 1'b1;
                        end
                        default: tx_ready_d = 1'b1;
                    endcase
                end
            end
            TX_START: state_d = TX_WAIT;
            TX_WAIT:  state_d = IDLE;
            TX_ABORT: begin
                // With tx_ready high we are draining the rest of the frame;
                // otherwise the buffer-clear write is on the bus this cycle.
                if (tx_ready) begin
                    if (tx_valid && tx_last) begin
                        csr_write_d     = 1'b1;
                        csr_address_d   = ADDR_TX_CTRL;
                        csr_writedata_d = 8'h04;
                        tx_err_d        = 1'b1;
                    end else begin
                        tx_ready_d = 1'b1;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_cdbus_host.sv
// Directed testbench for cdbus_host with a small cdbus CSR responder model.
module tb_cdbus_host;

    localparam logic [4:0] A_FLAG = 5'h10;
    localparam logic [4:0] A_RXD  = 5'h14;
    localparam logic [4:0] A_TXD  = 5'h15;
    localparam logic [4:0] A_RXC  = 5'h16;
    localparam logic [4:0] A_TXC  = 5'h17;

    logic       clk, reset_n, irq;
    logic [4:0] csr_address;
    logic       csr_read, csr_write;
    logic [7:0] csr_readdata, csr_writedata;
    logic [7:0] tx_data, rx_data;
    logic       tx_valid, tx_last, tx_ready;
    logic       rx_valid, rx_last, rx_ready;
    logic       tx_err, busy;

    cdbus_host dut (
        .clk(clk), .reset_n(reset_n), .irq(irq),
        .csr_address(csr_address), .csr_read(csr_read), .csr_readdata(csr_readdata),
        .csr_write(csr_write), .csr_writedata(csr_writedata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_last(tx_last), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_last(rx_last), .rx_ready(rx_ready),
        .tx_err(tx_err), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int tests_run = 0;
    int tests_failed = 0;

    // Responder state (written only by the responder process).
    int         wn = 0, rd_cnt = 0, err_cnt = 0, both_cnt = 0, rx_ptr = 0, rx_cleared = 0;
    logic [4:0] wa [0:127];
    logic [7:0] wd [0:127];
    // Stimulus state (written only by the main process).
    int         rx_posted = 0;
    logic       tx_clean = 1'b0;
    logic [7:0] rx_mem [0:31];
    logic [7:0] tx_seq [0:7];
    logic [7:0] got_d [0:15];
    logic       got_l [0:15];
    int         got_n;

    // cdbus CSR model: answers reads one cycle later, logs writes.
    initial begin
        csr_readdata = 8'h00;
        forever begin
            @(negedge clk);
            if (csr_read === 1'b1 && csr_write === 1'b1) both_cnt++;
            if (tx_err === 1'b1) err_cnt++;
            if (csr_read === 1'b1) begin
                rd_cnt++;
                if (csr_address == A_FLAG)
                    csr_readdata = {2'b00, tx_clean, 3'b000, (rx_posted != rx_cleared), 1'b0};
                else if (csr_address == A_RXD) begin
                    csr_readdata = rx_mem[rx_ptr];
                    rx_ptr++;
                end else
                    csr_readdata = 8'h00;
            end
            if (csr_write === 1'b1) begin
                if (wn < 128) begin
                    wa[wn] = csr_address;
                    wd[wn] = csr_writedata;
                end
                if (csr_address == A_RXC && csr_writedata == 8'h02) rx_cleared++;
                wn++;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_writes(input int target, input string tag);
        int n = 0;
        while (wn < target && n < 300) begin @(negedge clk); n++; end
        check({tag, "_write_count"}, 32'(wn >= target), 32'd1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        repeat (3) @(negedge clk);
        while (busy !== 1'b0 && n < 300) begin @(negedge clk); n++; end
        check({tag, "_idle"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic collect_rx(input int nb, input string tag);
        int n = 0;
        got_n = 0;
        while (got_n < nb && n < 400) begin
            if (rx_valid === 1'b1 && rx_ready === 1'b1) begin
                got_d[got_n] = rx_data;
                got_l[got_n] = rx_last;
                got_n++;
            end
            @(negedge clk);
            n++;
        end
        check({tag, "_rx_count"}, got_n, nb);
    endtask

    task automatic send_tx(input int nb, input int last_at, input string tag);
        int   n;
        logic ok = 1'b1;
        for (int i = 0; i < nb; i++) begin
            tx_data  = tx_seq[i];
            tx_valid = 1'b1;
            tx_last  = (i == last_at);
            n = 0;
            while (tx_ready !== 1'b1 && n < 300) begin @(negedge clk); n++; end
            if (n >= 300) ok = 1'b0;
            @(negedge clk);
        end
        tx_valid = 1'b0;
        tx_last  = 1'b0;
        check({tag, "_tx_handshake"}, {31'd0, ok}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_csr_read"}, {31'd0, csr_read}, 32'd0);
        check({tag, "_csr_write"}, {31'd0, csr_write}, 32'd0);
        check({tag, "_csr_address"}, {27'd0, csr_address}, 32'd0);
        check({tag, "_csr_writedata"}, {24'd0, csr_writedata}, 32'd0);
        check({tag, "_tx_ready"}, {31'd0, tx_ready}, 32'd0);
        check({tag, "_rx_valid"}, {31'd0, rx_valid}, 32'd0);
        check({tag, "_rx_last"}, {31'd0, rx_last}, 32'd0);
        check({tag, "_tx_err"}, {31'd0, tx_err}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int base, e0, r0, bad;
        logic [7:0] d0;

        reset_n = 1'b0; irq = 1'b0; tx_valid = 1'b0; tx_last = 1'b0;
        tx_data = 8'h00; rx_ready = 1'b1;
        for (int i = 0; i < 32; i++) rx_mem[i] = 8'h00;
        // frame 1: len 3; frame 2: len 0 (last at index 2); frame 3: len 1
        rx_mem[0] = 8'h01; rx_mem[1] = 8'h02; rx_mem[2] = 8'h03;
        rx_mem[3] = 8'hAA; rx_mem[4] = 8'hBB; rx_mem[5] = 8'hCC;
        rx_mem[6] = 8'h10; rx_mem[7] = 8'h20; rx_mem[8] = 8'h00;
        rx_mem[9] = 8'h01; rx_mem[10] = 8'h02; rx_mem[11] = 8'h01; rx_mem[12] = 8'h5A;

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        reset_n = 1'b1;

        // RX frame 01 02 03 AA BB CC
        repeat (3) @(negedge clk);
        base = wn;
        rx_posted++;
        irq = 1'b1; @(negedge clk); irq = 1'b0;
        collect_rx(6, "rx1");
        check("rx1_b0", got_d[0], 8'h01); check("rx1_b1", got_d[1], 8'h02);
        check("rx1_b2", got_d[2], 8'h03); check("rx1_b3", got_d[3], 8'hAA);
        check("rx1_b4", got_d[4], 8'hBB); check("rx1_b5", got_d[5], 8'hCC);
        check("rx1_last_mask", {got_l[5], got_l[4], got_l[3], got_l[2], got_l[1], got_l[0]}, 6'b100000);
        wait_writes(base + 1, "rx1");
        check("rx1_clr_addr", wa[base], A_RXC);
        check("rx1_clr_data", wd[base], 8'h02);
        wait_idle("rx1");
        check("rx1_writes_total", wn - base, 1);

        // Backpressure on frame 10 20 00 (len 0)
        rx_ready = 1'b0;
        base = wn;
        rx_posted++;
        irq = 1'b1; @(negedge clk); irq = 1'b0;
        e0 = 0;
        while (rx_valid !== 1'b1 && e0 < 300) begin @(negedge clk); e0++; end
        check("bp_valid_seen", {31'd0, rx_valid}, 32'd1);
        d0 = rx_data; r0 = rd_cnt; bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (rx_data !== d0 || rx_valid !== 1'b1) bad++;
        end
        check("bp_data_stable", bad, 0);
        check("bp_no_extra_read", rd_cnt, r0);
        check("bp_first_byte", d0, 8'h10);
        rx_ready = 1'b1;
        collect_rx(3, "bp");
        check("bp_b1", got_d[1], 8'h20); check("bp_b2", got_d[2], 8'h00);
        check("bp_last_mask", {got_l[2], got_l[1], got_l[0]}, 3'b100);
        wait_writes(base + 1, "bp");
        check("bp_clr_addr", wa[base], A_RXC);
        wait_idle("bp");

        // TX frame 05 06 02 11 22, last on 22
        tx_clean = 1'b1;
        base = wn;
        tx_seq = '{8'h05, 8'h06, 8'h02, 8'h11, 8'h22, 8'h00, 8'h00, 8'h00};
        send_tx(5, 4, "tx1");
        wait_writes(base + 6, "tx1");
        for (int i = 0; i < 5; i++) begin
            check($sformatf("tx1_addr%0d", i), wa[base + i], A_TXD);
            check($sformatf("tx1_data%0d", i), wd[base + i], tx_seq[i]);
        end
        check("tx1_start_addr", wa[base + 5], A_TXC);
        check("tx1_start_data", wd[base + 5], 8'h02);
        wait_idle("tx1");
        check("tx1_writes_total", wn - base, 6);

        // RX and TX pending together: RX frame must finish before any TX write
        base = wn;
        rx_posted++;
        fork
            collect_rx(4, "sim");
            send_tx(5, 4, "sim");
        join
        wait_writes(base + 7, "sim");
        check("sim_rx_last_byte", got_d[3], 8'h5A);
        check("sim_rx_last_flag", {got_l[3], got_l[2]}, 2'b10);
        check("sim_first_write_addr", wa[base], A_RXC);
        check("sim_first_write_data", wd[base], 8'h02);
        check("sim_tx_first_addr", wa[base + 1], A_TXD);
        check("sim_tx_start_addr", wa[base + 6], A_TXC);
        check("sim_tx_start_data", wd[base + 6], 8'h02);
        wait_idle("sim");

        // Early tx_last: 05 06 03 11, last on 11
        base = wn; e0 = err_cnt;
        tx_seq = '{8'h05, 8'h06, 8'h03, 8'h11, 8'h00, 8'h00, 8'h00, 8'h00};
        send_tx(4, 3, "early");
        wait_writes(base + 5, "early");
        check("early_data3", wd[base + 3], 8'h11);
        check("early_clr_addr", wa[base + 4], A_TXC);
        check("early_clr_data", wd[base + 4], 8'h04);
        wait_idle("early");
        check("early_writes_total", wn - base, 5);
        check("early_err_pulses", err_cnt - e0, 1);

        // Missing tx_last: 05 06 01 33 44 55, last on 55; 44 and 55 are drained
        base = wn; e0 = err_cnt;
        tx_seq = '{8'h05, 8'h06, 8'h01, 8'h33, 8'h44, 8'h55, 8'h00, 8'h00};
        send_tx(6, 5, "drain");
        wait_writes(base + 5, "drain");
        check("drain_data3", wd[base + 3], 8'h33);
        check("drain_clr_addr", wa[base + 4], A_TXC);
        check("drain_clr_data", wd[base + 4], 8'h04);
        wait_idle("drain");
        check("drain_writes_total", wn - base, 5);
        check("drain_err_pulses", err_cnt - e0, 1);

        // Reset during TX_LOAD
        tx_data = 8'h05; tx_valid = 1'b1; tx_last = 1'b0;
        e0 = 0;
        while (tx_ready !== 1'b1 && e0 < 300) begin @(negedge clk); e0++; end
        check("rst_in_tx_load", {31'd0, tx_ready}, 32'd1);
        reset_n = 1'b0; irq = 1'b1;
        @(negedge clk);
        check_reset_outputs("midrst");
        tx_valid = 1'b0; tx_clean = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("release_no_read", {31'd0, csr_read}, 32'd0);
        check("release_no_write", {31'd0, csr_write}, 32'd0);
        @(negedge clk);
        check("release_poll_read", {31'd0, csr_read}, 32'd1);
        check("release_poll_addr", csr_address, A_FLAG);
        irq = 1'b0;
        wait_idle("release");

        check("never_read_and_write", both_cnt, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
